// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and address-field helpers.
package icache_fetch_pkg;

  localparam int INDEX_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MISS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Line index of a byte address, right-aligned in a 32-bit result.
  function automatic logic [31:0] index_of(input logic [31:0] pc, input int unsigned index_w);
    logic [31:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag of a byte address, right-aligned in a 32-bit result.
  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned index_w);
    return pc >> (index_w + 2);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read,
// synchronous single-line write, and a one-cycle clear of every valid bit.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = 32 - 2 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // The clear is assigned last so it overrides a fill landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      if (clr)   valid_q <= '0;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether
  // a line is meaningful, and leaving them unreset lets them map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage
// and the memory controller's instruction port, with flush and invalidate.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter  int INDEX_W = INDEX_W_DEF,
  localparam int TAG_W   = 32 - 2 - INDEX_W
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        fetch_req_in,
  input  logic [31:0] fetch_pc_in,
  output logic        fetch_ready_out,
  output logic        fetch_valid_out,
  output logic [31:0] fetch_instr_out,
  input  logic        flush_in,
  input  logic        invalidate_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_instr_in
);

  state_e       state_q, state_d;
  logic [31:0]  miss_pc_q, miss_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic         fill;

  logic [INDEX_W-1:0] rd_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag, rd_tag;
  logic               rd_valid;
  logic [31:0]        rd_data;
  logic               hit;

  assign rd_idx   = INDEX_W'(index_of(fetch_pc_in, INDEX_W));
  assign req_tag  = TAG_W'(tag_of(fetch_pc_in, INDEX_W));
  assign fill_idx = INDEX_W'(index_of(miss_pc_q, INDEX_W));
  assign fill_tag = TAG_W'(tag_of(miss_pc_q, INDEX_W));
  assign hit      = rd_valid && (rd_tag == req_tag);

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .clr      (invalidate_in && rdy_in),
    .wr_en    (fill && rdy_in),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_data  (mem_instr_in),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign fetch_ready_out = (state_q == ST_IDLE) && !flush_in;
  // Dropped in the done cycle so the controller never sees a fresh request.
  assign mem_req_out     = ((state_q == ST_MISS) || (state_q == ST_DRAIN)) && !mem_done_in;
  assign mem_addr_out    = {miss_pc_q[31:2], 2'b00};
  assign fetch_valid_out = valid_q;
  assign fetch_instr_out = instr_q;

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    valid_d   = 1'b0;
    instr_d   = instr_q;
    fill      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req_in && fetch_ready_out) begin
          if (hit) begin
            valid_d = 1'b1;
            instr_d = rd_data;
          end else begin
            miss_pc_d = fetch_pc_in;
            state_d   = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (mem_done_in) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
          if (!flush_in) begin
            valid_d = 1'b1;
            instr_d = mem_instr_in;
          end
        end else if (flush_in) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The fill still lands, but the flushed requester gets no response.
        if (mem_done_in) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      miss_pc_q <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
    end
  end

endmodule
